// File: rtl/vedic_seq_mul.sv
// Sequential Vedic multiplier: walks all D*D pairs of 2-bit operand digits
// through one 2x2 Urdhva-Tiryagbhyam cell. Each 4-bit digit product is
// shifted by 2*(i+j) and added into a 2*WIDTH-bit accumulator.
// Upstream and downstream connect through valid/ready handshakes.
module vedic_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y,
  output logic                 busy
);

  localparam int D     = WIDTH / 2;
  // At least one index bit, so that WIDTH=2 still has a legal index type.
  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam int NDIG  = 1 << IDX_W;
  localparam int SH_W  = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   y_q;
  logic [IDX_W-1:0]     i_q;
  logic [IDX_W-1:0]     j_q;
  logic                 out_valid_q;
  logic                 busy_q;

  // Latched operands split into digit arrays. The arrays are padded with
  // zero digits up to a power of two so that every index value is in range.
  logic [1:0] a_dig [NDIG];
  logic [1:0] b_dig [NDIG];

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_dig
      if (gi < D) begin : g_real
        assign a_dig[gi] = a_q[2*gi +: 2];
        assign b_dig[gi] = b_q[2*gi +: 2];
      end else begin : g_pad
        assign a_dig[gi] = 2'b00;
        assign b_dig[gi] = 2'b00;
      end
    end
  endgenerate

  // 2x2 vertical-and-crosswise cell: the vertical terms give bits 0 and 2.
  // The crosswise sum gives bit 1, and its carry ripples into bits 2 and 3.
  logic [1:0] da;
  logic [1:0] db;
  logic       cross_lo;
  logic       cross_hi;
  logic       vert_hi;
  logic       cross_carry;
  logic [3:0] pp;

  assign da          = a_dig[i_q];
  assign db          = b_dig[j_q];
  assign cross_lo    = da[1] & db[0];
  assign cross_hi    = da[0] & db[1];
  assign vert_hi     = da[1] & db[1];
  assign cross_carry = cross_lo & cross_hi;
  assign pp[0]       = da[0] & db[0];
  assign pp[1]       = cross_lo ^ cross_hi;
  assign pp[2]       = vert_hi ^ cross_carry;
  assign pp[3]       = vert_hi & cross_carry;

  // Digit weight is 4^(i+j), i.e. a left shift of 2*(i+j) bits.
  logic [SH_W-1:0] sh_amt;
  assign sh_amt = (SH_W'(i_q) + SH_W'(j_q)) << 1;
  assign acc_d  = acc_q + ((2 * WIDTH)'(pp) << sh_amt);

  // Control FSM with operand latch, accumulator, digit walk and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          if (j_q == LAST_IDX) begin
            j_q <= '0;
            if (i_q == LAST_IDX) begin
              // This cycle adds the final partial product. The result is
              // published straight from the adder so that y changes only here.
              y_q         <= acc_d;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_DONE;
            end else begin
              i_q <= i_q + IDX_W'(1);
            end
          end else begin
            j_q <= j_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // in_ready is forced low for as long as reset is held, without waiting for a clock edge.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vedic_seq_mul.sv
// Bench for vedic_seq_mul at WIDTH=8, 4 and 2. Each accepted operand pair
// pushes its expected product to a per-width queue. The entry is popped
// and compared when out_valid appears.
module tb_vedic_seq_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] y8;

  logic        iv4, ir4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  y4;

  logic        iv2, ir2, ov2, or2, busy2;
  logic [1:0]  a2, b2;
  logic [3:0]  y2;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp8 [$];
  logic [7:0]  exp4 [$];
  logic [3:0]  exp2 [$];

  vedic_seq_mul #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .y(y8), .busy(busy8)
  );

  vedic_seq_mul #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .y(y4), .busy(busy4)
  );

  vedic_seq_mul #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2), .y(y2), .busy(busy2)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required summary");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready8(output bit ok);
    int n = 0;
    while (ir8 !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    ok = (ir8 === 1'b1);
    if (!ok) begin
      bad++;
      $display("FAIL wait_ready8: in_ready got %b required 1", ir8);
    end
  endtask

  // One WIDTH=8 operation. With stall > 0, out_ready is held low for that many cycles of DONE.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input int stall, input string name);
    bit ok;
    int lat;
    logic [15:0] exp;
    wait_ready8(ok);
    if (!ok) return;
    a8  = a;
    b8  = b;
    iv8 = 1'b1;
    or8 = (stall == 0);
    exp8.push_back(16'(a) * 16'(b));
    tick();
    iv8 = 1'b0;
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    lat = 0;
    while (ov8 !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    total++;
    if (lat != 16) begin
      bad++;
      $display("FAIL %s latency: got %0d required 16", name, lat);
    end
    exp = exp8.pop_front();
    total++;
    if (y8 !== exp) begin
      bad++;
      $display("FAIL %s product a=%0d b=%0d: y got %0d required %0d", name, a, b, y8, exp);
    end
    for (int k = 0; k < stall; k++) begin
      iv8 = 1'b1;
      total++;
      if (ov8 !== 1'b1 || y8 !== exp || ir8 !== 1'b0) begin
        bad++;
        $display("FAIL %s hold cycle %0d: out_valid=%b y=%0d in_ready=%b required 1 %0d 0",
                 name, k, ov8, y8, ir8, exp);
      end
      tick();
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    tick();
    total++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      bad++;
      $display("FAIL %s return_idle: out_valid=%b in_ready=%b required 0 1", name, ov8, ir8);
    end
    $display("txn %s a=%0d b=%0d y=%0d lat=%0d", name, a, b, exp, lat);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    iv8 = 0; or8 = 1; a8 = 0; b8 = 0;
    iv4 = 0; or4 = 1; a4 = 0; b4 = 0;
    iv2 = 0; or2 = 1; a2 = 0; b2 = 0;
    #1;
    total++;
    if (ir8 !== 1'b0 || ov8 !== 1'b0 || y8 !== 16'd0 || busy8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b y=%0d busy=%b required 0 0 0 0",
               ir8, ov8, y8, busy8);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (ir8 !== 1'b1 || ir4 !== 1'b1 || ir2 !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: in_ready 8/4/2 got %b%b%b required 111", ir8, ir4, ir2);
    end
    $display("txn reset done");
  endtask

  task automatic test_basic;
    run8(8'd3, 8'd3, 0, "basic");
  endtask

  task automatic test_max;
    run8(8'd255, 8'd255, 0, "max");
    run8(8'd0, 8'd200, 0, "zero");
    run8(8'd170, 8'd85, 0, "alt");
  endtask

  task automatic test_backpressure;
    run8(8'd12, 8'd34, 10, "backpressure");
  endtask

  task automatic test_busy_ignore;
    bit ok;
    int lat;
    int extra;
    logic [15:0] exp;
    wait_ready8(ok);
    if (!ok) return;
    a8 = 8'd7; b8 = 8'd9; iv8 = 1'b1; or8 = 1'b1;
    exp8.push_back(16'd63);
    tick();
    a8 = 8'd100; b8 = 8'd100;
    total++;
    if (busy8 !== 1'b1 || ir8 !== 1'b0) begin
      bad++;
      $display("FAIL busy_flag: busy=%b in_ready=%b required 1 0", busy8, ir8);
    end
    lat = 0;
    while (ov8 !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    iv8 = 1'b0;
    total++;
    if (lat != 16) begin
      bad++;
      $display("FAIL busy_ignore latency: got %0d required 16", lat);
    end
    exp = exp8.pop_front();
    total++;
    if (y8 !== exp) begin
      bad++;
      $display("FAIL busy_ignore product: y got %0d required %0d", y8, exp);
    end
    tick();
    extra = 0;
    repeat (30) begin
      tick();
      if (ov8 === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL busy_ignore extra_products: got %0d required 0", extra);
    end
    $display("txn busy_ignore a=7 b=9 y=%0d lat=%0d", exp, lat);
  endtask

  task automatic test_reset_mid;
    bit ok;
    int seen;
    wait_ready8(ok);
    if (!ok) return;
    a8 = 8'd9; b8 = 8'd11; iv8 = 1'b1; or8 = 1'b1;
    tick();
    iv8 = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    total++;
    if (ov8 !== 1'b0 || y8 !== 16'd0 || busy8 !== 1'b0 || ir8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid async: out_valid=%b y=%0d busy=%b in_ready=%b required 0 0 0 0",
               ov8, y8, busy8, ir8);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (ir8 !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid release: in_ready got %b required 1", ir8);
    end
    seen = 0;
    repeat (20) begin
      tick();
      if (ov8 === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_mid discarded: out_valid cycles got %0d required 0", seen);
    end
    $display("txn reset_mid aborted a=9 b=11");
    run8(8'd5, 8'd6, 0, "after_reset");
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 4; n++) begin
      run8(8'($urandom), 8'($urandom), 0, "random");
    end
  endtask

  task automatic test_sweep2;
    int lat;
    int w;
    logic [3:0] exp;
    for (int x = 0; x < 4; x++) begin
      for (int z = 0; z < 4; z++) begin
        w = 0;
        while (ir2 !== 1'b1 && w < 20) begin
          tick();
          w++;
        end
        a2 = 2'(x); b2 = 2'(z); iv2 = 1'b1; or2 = 1'b1;
        exp2.push_back(4'(x * z));
        tick();
        iv2 = 1'b0;
        lat = 0;
        while (ov2 !== 1'b1 && lat < 20) begin
          tick();
          lat++;
        end
        exp = exp2.pop_front();
        total++;
        if (lat != 1 || y2 !== exp) begin
          bad++;
          $display("FAIL sweep2 a=%0d b=%0d: y=%0d lat=%0d required %0d lat 1", x, z, y2, lat, exp);
        end
        $display("txn sweep2 a=%0d b=%0d y=%0d", x, z, y2);
        tick();
      end
    end
  endtask

  task automatic test_sweep4;
    int lat;
    int w;
    logic [7:0] exp;
    for (int x = 0; x < 16; x++) begin
      for (int z = 0; z < 16; z++) begin
        w = 0;
        while (ir4 !== 1'b1 && w < 20) begin
          tick();
          w++;
        end
        a4 = 4'(x); b4 = 4'(z); iv4 = 1'b1; or4 = 1'b1;
        exp4.push_back(8'(x * z));
        tick();
        iv4 = 1'b0;
        lat = 0;
        while (ov4 !== 1'b1 && lat < 20) begin
          tick();
          lat++;
        end
        exp = exp4.pop_front();
        total++;
        if (lat != 4 || y4 !== exp) begin
          bad++;
          $display("FAIL sweep4 a=%0d b=%0d: y=%0d lat=%0d required %0d lat 4", x, z, y4, lat, exp);
        end
        $display("txn sweep4 a=%0d b=%0d y=%0d", x, z, y4);
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_sweep2();
    test_sweep4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
